// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO and MTHI/MTLO writes
// Ports: clk, reset (sync, active-low); start/op/operand_a/operand_b launch an operation;
// flush aborts it; hi_we/lo_we/wdata service MTHI/MTLO; hi/lo hold results;
// busy stalls the pipeline, done pulses on result write, div_zero flags a divide by zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t               state;
  logic [1:0]           op_r;
  logic                 neg_q, neg_r, b_zero;
  logic [WIDTH-1:0]     mag_b, a_raw;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 sa, sb;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   acc_next, prod;
  logic [WIDTH-1:0]     quo, rem;
  always_comb begin
    sa = ~op[0] & operand_a[WIDTH-1];
    sb = ~op[0] & operand_b[WIDTH-1];
    // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mag_b : '0};
    // divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step;
    // trial[WIDTH] is the borrow, so a clear MSB means the trial remainder is >= 0
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    acc_next = op_r[1] ? (div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                           : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                       : {mul_sum, acc[WIDTH-1:1]};
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      op_r     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      mag_b    <= '0;
      a_raw    <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            op_r   <= op;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= operand_b == '0;
            a_raw  <= operand_a;
            mag_b  <= sb ? -operand_b : operand_b;
            acc    <= {{WIDTH{1'b0}}, sa ? -operand_a : operand_a};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (!op_r[1]) {hi, lo} <= prod;
            else if (b_zero) begin
              hi       <= a_raw;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi       <= rem;
              lo       <= quo;
              div_zero <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven and directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;
  int checks = 0;
  int failures = 0;
  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  // drives a start for one cycle, then scrambles the operands; returns at the negedge after the start edge
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; op = ~o; operand_a = 32'h5EED_0000; operand_b = 32'h0000_0BAD;
  endtask
  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
  endtask
  initial begin
    int n, bc, dcnt;
    logic [31:0] hi_s, lo_s;
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{2'b10, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'd6,        32'd7,        32'd0,        32'd42,       1'b1};
    vecs[7]  = '{2'b11, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0};
    vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0};
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b1;
    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(n, bc);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'd33);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd33);
      chk($sformatf("v%0d_hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      chk($sformatf("v%0d_div_zero", i), {63'd0, div_zero}, {63'd0, vecs[i].dz});
      @(negedge clk);
      chk($sformatf("v%0d_done_once", i), {63'd0, done}, 64'd0);
    end
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
    chk("mthi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    hi_s = hi; lo_s = lo;
    launch(2'b00, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_hilo_kept", {hi, lo}, {hi_s, lo_s});
    launch(2'b00, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd7;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("we_while_busy", {hi, lo}, {hi_s, lo_s});
    wait_done(n, bc);
    chk("start_while_busy_hilo", {hi, lo}, {32'd0, 32'd12});
    start = 1'b1; op = 2'b11; operand_a = 32'd9; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_busy", {63'd0, busy}, 64'd1);
    wait_done(n, bc);
    chk("start_on_done_latency", 64'(n), 64'd33);
    chk("start_on_done_hilo", {hi, lo}, {32'd0, 32'd3});
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h11111111;
    launch(2'b01, 32'd2, 32'd3);
    hi_we = 1'b0;
    chk("we_with_start_hi", {32'd0, hi}, {32'd0, 32'h11111111});
    wait_done(n, bc);
    chk("we_with_start_final", {hi, lo}, {32'd0, 32'd6});
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; operand_a = 32'd5; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", {63'd0, busy}, 64'd0);
    launch(2'b10, 32'd5, 32'd0);
    wait_done(n, bc);
    chk("div0_again", {31'd0, div_zero, hi}, {31'd0, 1'b1, 32'd5});
    launch(2'b00, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset_hilo", {hi, lo}, 64'd0);
    chk("midreset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("midreset_no_result", {32'(dcnt), lo}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the operand and control values that the ID/EX pipeline register delivers. Executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers.
- Drives a busy signal back to the hazard logic so the ID/EX and earlier stages stall until the result is ready.
- Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all logic updates on posedge.
- reset  input  1  synchronous, active-low; 0 = reset.
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  WIDTH  rs value (multiplicand / dividend).
- operand_b  input  WIDTH  rt value (multiplier / divisor).
- flush  input  1  abort the in-flight operation (branch/exception squash).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  registered; 1 while state != IDLE.
- done  output  1  registered; one-cycle pulse when hi/lo receive a result.
- div_zero  output  1  registered; sticky flag, set when the last divide had operand_b == 0.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Counter and internal datapath registers cleared.
  - Reset overrides every other input, including mid-operation; no result is written.
- States: IDLE, CALC, FINISH.
- IDLE, start=1 at edge T0:
  - Latch op.
  - For signed ops (MULT, DIV), latch |operand_a| and |operand_b| plus sign bits. Result sign is sa^sb; remainder sign is sa.
  - Counter=0, state->CALC, busy=1 from T0.
- CALC, one iteration per edge, exactly WIDTH edges (T0+1 .. T0+WIDTH):
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. The quotient bit is 1 when the trial remainder is >= 0.
  - After the iteration with counter==WIDTH-1, state->FINISH.
- FINISH (edge T0+WIDTH+1):
  - Apply sign correction: two's-complement negate the product, quotient or remainder as required.
  - Multiply: {hi,lo} = 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder. Quotient truncates toward zero.
  - Divide with operand_b==0: lo = all ones, hi = the operand_a value latched at T0, div_zero=1. Signedness is ignored.
  - Any non-zero divide clears div_zero. Multiplies leave div_zero unchanged.
  - done=1 for exactly this one cycle. busy=0 and state->IDLE.
  - Total latency: start edge to hi/lo/done valid = WIDTH+1 edges (33 by default). busy is high for WIDTH+1 cycles.
- start while busy: ignored; no queuing.
- start in the same cycle that done is high: accepted, because the state is already IDLE.
- flush:
  - In CALC or FINISH: state->IDLE, busy=0 next cycle, done=0, hi/lo/div_zero unchanged.
  - In IDLE together with start: flush wins and start is dropped.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata into hi/lo at the edge. Both may be asserted together.
  - When busy, hi_we/lo_we are ignored. The hazard unit must stall them.
  - hi_we with start in the same IDLE cycle: the write takes effect, and the later FINISH overwrites it.
- Operands are captured only at the start edge. Later changes on operand_a/operand_b or op have no effect.
- hi/lo change only at reset, on a FINISH edge, or on an accepted MTHI/MTLO write.

Test Plan:
- MULT a=32'hFFFFFFFD (-3), b=5 -> after 33 edges: hi=32'hFFFFFFFF, lo=32'hFFFFFFF1, done pulses once, busy high 33 cycles.
- MULTU a=32'hFFFFFFFF, b=2 -> hi=32'h00000001, lo=32'hFFFFFFFE; DIVU a=100, b=7 -> lo=14, hi=2, div_zero=0.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIV a=7, b=-2 -> lo=-3, hi=1.
- DIV a=32'h12345678, b=0 -> lo=32'hFFFFFFFF, hi=32'h12345678, div_zero=1; a following DIVU 9/3 clears div_zero, lo=3, hi=0.
- Start MULT 6*7, pulse flush at CALC cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values. Start asserted while busy is ignored: the result matches the first operation only.
- Mid-CALC reset=0 for one cycle -> all outputs 0 next edge. MTHI 32'hA5A5A5A5 in IDLE -> hi updated. hi_we while busy -> hi unchanged.
